// File: rtl/cl_ocl_mstr_pkg.sv
// rtl/cl_ocl_mstr_pkg.sv - shared types and constants for the OCL AXI4-Lite master
// Contents: FSM state enum, command/response holding structs, response codes.
package cl_ocl_mstr_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        RSP    = 3'd5,
        DRAIN  = 3'd6
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
    } rsp_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/cl_ocl_mstr.sv
// rtl/cl_ocl_mstr.sv - single-beat command/response to AXI4-Lite master with response watchdog
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_*                      command stream (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                      response stream (valid/ready, rdata, resp, timeout)
//   aw*/w*/b*/ar*/r*           AXI4-Lite master channels towards an OCL register slave
module cl_ocl_mstr
    import cl_ocl_mstr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp
);

    state_t      state, state_nxt;
    // Bus phase still outstanding after a watchdog response; IDLE when the bus is quiet.
    state_t      pend, pend_nxt;
    state_t      bus_st, bus_nxt;
    cmd_t        cmd_q, cmd_nxt;
    rsp_t        rsp_q, rsp_nxt;
    logic        aw_done, aw_done_nxt;
    logic        w_done, w_done_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        aw_hs, w_hs, b_hs, r_hs;
    logic        bus_cpl;
    logic        timeout_hit;

    // The bus channels follow the FSM state directly, except while the response
    // or drain is in progress, where they follow the saved outstanding phase so
    // that valids are never withdrawn before their handshake.
    always_comb begin
        bus_st = state;
        if (state == RSP || state == DRAIN) begin
            bus_st = pend;
        end
    end

    assign awvalid = (bus_st == WR_REQ) && !aw_done;
    assign wvalid  = (bus_st == WR_REQ) && !w_done;
    assign bready  = (bus_st == WR_RSP);
    assign arvalid = (bus_st == RD_REQ);
    assign rready  = (bus_st == RD_RSP);

    assign awaddr = cmd_q.addr;
    assign araddr = cmd_q.addr;
    assign wdata  = cmd_q.wdata;
    assign wstrb  = cmd_q.wstrb;
    assign awprot = 3'b000;
    assign arprot = 3'b000;

    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_resp    = rsp_q.resp;
    assign rsp_timeout = rsp_q.timeout;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bready && bvalid;
    assign r_hs  = rready && rvalid;

    assign bus_cpl     = cmd_q.write ? b_hs : r_hs;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES);

    // Next bus phase given this cycle's handshakes.
    always_comb begin
        bus_nxt = bus_st;
        case (bus_st)
            WR_REQ: if ((aw_done || aw_hs) && (w_done || w_hs)) bus_nxt = WR_RSP;
            WR_RSP: if (bvalid) bus_nxt = IDLE;
            RD_REQ: if (arready) bus_nxt = RD_RSP;
            RD_RSP: if (rvalid) bus_nxt = IDLE;
            default: bus_nxt = IDLE;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        pend_nxt    = pend;
        cmd_nxt     = cmd_q;
        rsp_nxt     = rsp_q;
        aw_done_nxt = aw_done || aw_hs;
        w_done_nxt  = w_done || w_hs;
        cnt_nxt     = cnt;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_nxt.write = cmd_write;
                    cmd_nxt.addr  = cmd_addr;
                    cmd_nxt.wdata = cmd_wdata;
                    cmd_nxt.wstrb = cmd_wstrb;
                    state_nxt     = cmd_write ? WR_REQ : RD_REQ;
                    aw_done_nxt   = 1'b0;
                    w_done_nxt    = 1'b0;
                    cnt_nxt       = '0;
                    pend_nxt      = IDLE;
                end
            end
            WR_REQ, WR_RSP, RD_REQ, RD_RSP: begin
                cnt_nxt = cnt + 32'd1;
                // A real bus response wins over a watchdog expiring in the same cycle.
                if (bus_cpl) begin
                    rsp_nxt.rdata   = cmd_q.write ? 32'd0 : rdata;
                    rsp_nxt.resp    = cmd_q.write ? bresp : rresp;
                    rsp_nxt.timeout = 1'b0;
                    pend_nxt        = IDLE;
                    state_nxt       = RSP;
                end else if (timeout_hit) begin
                    rsp_nxt.rdata   = 32'd0;
                    rsp_nxt.resp    = RESP_SLVERR;
                    rsp_nxt.timeout = 1'b1;
                    pend_nxt        = bus_nxt;
                    state_nxt       = RSP;
                end else begin
                    state_nxt = bus_nxt;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                pend_nxt  = bus_nxt;
                if (rsp_ready) begin
                    state_nxt = (bus_nxt == IDLE) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                pend_nxt = bus_nxt;
                if (bus_nxt == IDLE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend    <= IDLE;
            cmd_q   <= '0;
            rsp_q   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            cmd_q   <= cmd_nxt;
            rsp_q   <= rsp_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            cnt     <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_cl_ocl_mstr.sv
// tb/tb_cl_ocl_mstr.sv - directed self-checking bench for cl_ocl_mstr with a behavioural register slave
module tb_cl_ocl_mstr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int total = 0;
    int bad = 0;

    // slave knobs (written by the stimulus only)
    int aw_delay = 0;
    int w_delay = 0;
    int b_delay = 0;
    int r_delay = 0;

    // slave state
    int          aw_wait, w_wait, b_wait, r_wait;
    int          b_hs_cnt;
    logic        got_aw, got_w, r_pend;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] regs [0:2];

    always #5 clk = ~clk;

    cl_ocl_mstr #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid && (w_wait >= w_delay);
    assign arready = arvalid;
    assign bresp   = 2'b00;
    assign rresp   = 2'b00;

    // Register slave: 0x500/0x504/0x508 storage, everything else reads 0xDEADBEEF.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; r_wait <= 0;
            b_hs_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; rdata <= '0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_araddr <= '0;
            regs[0] <= '0; regs[1] <= '0; regs[2] <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            if (awvalid && awready) begin
                got_aw <= 1'b1;
                s_awaddr <= awaddr;
            end
            if (wvalid && wready) begin
                got_w <= 1'b1;
                s_wdata <= wdata;
                s_wstrb <= wstrb;
            end
            if (got_aw && got_w && !bvalid) begin
                if (b_wait >= b_delay) begin
                    bvalid <= 1'b1;
                    got_aw <= 1'b0;
                    got_w <= 1'b0;
                    b_wait <= 0;
                    for (int i = 0; i < 4; i++) begin
                        if (s_wstrb[i]) begin
                            case (s_awaddr)
                                32'h500: regs[0][8*i +: 8] <= s_wdata[8*i +: 8];
                                32'h504: regs[1][8*i +: 8] <= s_wdata[8*i +: 8];
                                32'h508: regs[2][8*i +: 8] <= s_wdata[8*i +: 8];
                                default: ;
                            endcase
                        end
                    end
                end else begin
                    b_wait <= b_wait + 1;
                end
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                b_hs_cnt <= b_hs_cnt + 1;
            end
            if (arvalid && arready) begin
                r_pend <= 1'b1;
                r_wait <= 0;
                s_araddr <= araddr;
            end
            if (r_pend && !rvalid) begin
                if (r_wait >= r_delay) begin
                    rvalid <= 1'b1;
                    r_pend <= 1'b0;
                    case (s_araddr)
                        32'h500: rdata <= regs[0];
                        32'h504: rdata <= regs[1];
                        32'h508: rdata <= regs[2];
                        default: rdata <= 32'hDEAD_BEEF;
                    endcase
                end else begin
                    r_wait <= r_wait + 1;
                end
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL cmd_accept: cmd_ready stayed %0b for %0d cycles, required 1", cmd_ready, n);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic [1:0] r, output logic t);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL rsp_wait: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, n);
        end
        d = rsp_rdata;
        r = rsp_resp;
        t = rsp_timeout;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
        total++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin bad++; $display("FAIL reset_valids: got %b want 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}); end
        total++; if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'd0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", {rsp_rdata, rsp_resp, rsp_timeout}); end
        total++; if ({awaddr, wdata, wstrb, araddr} !== 100'd0) begin bad++; $display("FAIL reset_bus_data: got %h want 0", {awaddr, wdata, wstrb, araddr}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic [1:0] r; logic t;
        send_cmd(1'b1, 32'h500, 32'h1234_5678, 4'hF);
        wait_rsp(d, r, t);
        total++; if (r !== 2'b00 || t !== 1'b0) begin bad++; $display("FAIL wr_resp: got resp=%b tmo=%b want 00/0", r, t); end
        total++; if (d !== 32'd0) begin bad++; $display("FAIL wr_rdata: got %h want 0", d); end
        send_cmd(1'b0, 32'h500, 32'h0, 4'h0);
        total++; if (arvalid !== 1'b1 || araddr !== 32'h500 || arprot !== 3'b000) begin bad++; $display("FAIL rd_issue: got arvalid=%b araddr=%h arprot=%b want 1/500/000", arvalid, araddr, arprot); end
        wait_rsp(d, r, t);
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL rd_rdata: got %h want 12345678", d); end
        total++; if (r !== 2'b00 || t !== 1'b0) begin bad++; $display("FAIL rd_resp: got resp=%b tmo=%b want 00/0", r, t); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic [1:0] r; logic t;
        send_cmd(1'b0, 32'h600, 32'h0, 4'h0);
        wait_rsp(d, r, t);
        total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL unmapped_rdata: got %h want deadbeef", d); end
        total++; if (r !== 2'b00) begin bad++; $display("FAIL unmapped_resp: got %b want 00", r); end
    endtask

    task automatic test_skew();
        logic [31:0] d; logic [1:0] r; logic t;
        int aw_cyc, w_cyc, stable_bad, b0, n;
        aw_delay = 5;
        w_delay = 0;
        b0 = b_hs_cnt;
        aw_cyc = 0; w_cyc = 0; stable_bad = 0; n = 0;
        send_cmd(1'b1, 32'h504, 32'hA5A5_BEEF, 4'h3);
        while (!rsp_valid && n < 40) begin
            if (awvalid) aw_cyc++;
            if (wvalid) w_cyc++;
            if (awvalid && (awaddr !== 32'h504 || awprot !== 3'b000)) stable_bad++;
            if (wvalid && (wdata !== 32'hA5A5_BEEF || wstrb !== 4'h3)) stable_bad++;
            @(negedge clk);
            n++;
        end
        wait_rsp(d, r, t);
        aw_delay = 0;
        total++; if (aw_cyc !== 6) begin bad++; $display("FAIL skew_aw_cycles: got %0d want 6", aw_cyc); end
        total++; if (w_cyc !== 1) begin bad++; $display("FAIL skew_w_cycles: got %0d want 1", w_cyc); end
        total++; if (stable_bad !== 0) begin bad++; $display("FAIL skew_stable: got %0d unstable cycles want 0", stable_bad); end
        total++; if (b_hs_cnt - b0 !== 1) begin bad++; $display("FAIL skew_b_count: got %0d want 1", b_hs_cnt - b0); end
        total++; if (r !== 2'b00) begin bad++; $display("FAIL skew_resp: got %b want 00", r); end
        send_cmd(1'b0, 32'h504, 32'h0, 4'h0);
        wait_rsp(d, r, t);
        total++; if (d !== 32'h0000_BEEF) begin bad++; $display("FAIL skew_strobe_readback: got %h want 0000beef", d); end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        send_cmd(1'b0, 32'h500, 32'h0, 4'h0);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid); end
            total++; if (rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL bp_rdata[%0d]: got %h want 12345678", i, rsp_rdata); end
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_cmd_ready[%0d]: got %b want 0", i, cmd_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got cmd_ready=%b rsp_valid=%b want 1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic [1:0] r; logic t;
        int k, n;
        r_delay = 38;
        send_cmd(1'b0, 32'h508, 32'h0, 4'h0);
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL tmo_issue: got arvalid=%b want 1", arvalid); end
        k = 0;
        while (!rsp_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        total++; if (k !== 17) begin bad++; $display("FAIL tmo_latency: got %0d cycles want 17", k); end
        total++; if (rsp_timeout !== 1'b1 || rsp_resp !== 2'b10) begin bad++; $display("FAIL tmo_rsp: got tmo=%b resp=%b want 1/10", rsp_timeout, rsp_resp); end
        total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL tmo_rdata: got %h want 0", rsp_rdata); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (cmd_ready !== 1'b0 || rready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL tmo_drain: got cmd_ready=%b rready=%b rsp_valid=%b want 0/1/0", cmd_ready, rready, rsp_valid); end
        n = 0;
        while (!(rvalid && rready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (n >= 100) begin bad++; $display("FAIL tmo_late_beat: no R beat after %0d cycles, required one", n); end
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rready !== 1'b0) begin bad++; $display("FAIL tmo_after_drain: got cmd_ready=%b rsp_valid=%b rready=%b want 1/0/0", cmd_ready, rsp_valid, rready); end
        r_delay = 0;
        send_cmd(1'b0, 32'h500, 32'h0, 4'h0);
        wait_rsp(d, r, t);
        total++; if (d !== 32'h1234_5678 || r !== 2'b00 || t !== 1'b0) begin bad++; $display("FAIL tmo_recover: got %h/%b/%b want 12345678/00/0", d, r, t); end
    endtask

    task automatic test_reset_mid();
        int n;
        b_delay = 20;
        n = 0;
        send_cmd(1'b1, 32'h500, 32'hCAFE_F00D, 4'hF);
        while (!bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++; if (bready !== 1'b1) begin bad++; $display("FAIL mid_wr_rsp: got bready=%b want 1", bready); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin bad++; $display("FAIL mid_async_valids: got %b want 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}); end
        @(negedge clk);
        rst_n = 1'b1;
        b_delay = 0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin bad++; $display("FAIL mid_release: got cmd_ready=%b rsp_valid=%b rdata=%h want 1/0/0", cmd_ready, rsp_valid, rsp_rdata); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_unmapped();
        test_skew();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
